// File: rtl/snn_phase_controller_pkg.sv
// Shared definitions for the SNN phase controller: 3-bit phase encoding.
package snn_ctrl_pkg;

    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE = 3'd0,
        ST_INIT = 3'd1,
        ST_LERN = 3'd2,
        ST_LRST = 3'd3,
        ST_STDP = 3'd4,
        ST_INFR = 3'd5,
        ST_IRST = 3'd6,
        ST_DONE = 3'd7
    } state_t;

endpackage

// File: rtl/snn_phase_controller_if.sv
// Phase handshake between the controller (master) and the neuron channel groups (slave).
interface snn_phase_controller_if #(
    parameter int unsigned N_CH = 8
);
    logic [N_CH-1:0] i_ch_en;
    logic [N_CH-1:0] i_syn_done;
    logic [N_CH-1:0] i_inh_valid;
    logic [N_CH-1:0] i_stdp_done;
    logic            o_init;
    logic            o_run;
    logic            o_rest_run;
    logic            o_stdp_run;

    modport master (
        input  i_ch_en, i_syn_done, i_inh_valid, i_stdp_done,
        output o_init, o_run, o_rest_run, o_stdp_run
    );

    modport slave (
        output i_ch_en, i_syn_done, i_inh_valid, i_stdp_done,
        input  o_init, o_run, o_rest_run, o_stdp_run
    );
endinterface

// File: rtl/snn_delay_line.sv
// Fixed-depth shift register with synchronous clear.
module snn_delay_line #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);
    logic [WIDTH-1:0] taps [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) taps[i] <= '0;
        end else begin
            taps[0] <= din;
            for (int unsigned i = 1; i < DEPTH; i++) taps[i] <= taps[i-1];
        end
    end

    assign dout = taps[DEPTH-1];
endmodule

// File: rtl/snn_phase_controller.sv
// Sequences init, learning (run/rest/STDP) and inference phases over the neuron channel groups.
module snn_phase_controller
    import snn_ctrl_pkg::*;
#(
    parameter int unsigned N_CH        = 8,
    parameter int unsigned TS_W        = 11,
    parameter int unsigned LERN_STEPS  = 800,
    parameter int unsigned TOTAL_STEPS = 1200,
    parameter int unsigned SUB_LOG2    = 7,
    parameter int unsigned INH_DLY     = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_init,
    input  logic                  i_lern,
    input  logic                  i_infr,
    input  logic                  i_abort,
    snn_phase_controller_if.master ch,
    output logic                  o_cnt_clr,
    output logic                  o_s_lern,
    output logic                  o_s_infr,
    output logic                  o_sub,
    output logic                  o_s_stdp,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [TS_W-1:0]       o_time_step
);
    localparam logic [TS_W-1:0] LERN_TS  = TS_W'(LERN_STEPS);
    localparam logic [TS_W-1:0] TOTAL_TS = TS_W'(TOTAL_STEPS);

    state_t          state_q, state_d;
    logic            entry_q;
    logic            infr_flow_q;
    logic [TS_W-1:0] time_step_q, inf_step_q;
    logic            syn_rdy, inh_rdy, stdp_rdy, inh_d;
    logic            ts_inc, inf_inc;
    logic            init_p, run_p, rest_p, stdp_p;

    // Disabled channels never hold up a phase.
    assign syn_rdy  = &(ch.i_syn_done  | ~ch.i_ch_en);
    assign inh_rdy  = &(ch.i_inh_valid | ~ch.i_ch_en);
    assign stdp_rdy = &(ch.i_stdp_done | ~ch.i_ch_en);

    snn_delay_line #(.WIDTH(1), .DEPTH(INH_DLY)) u_inh_dly (
        .clk   (clk),
        .reset (reset),
        .din   (inh_rdy),
        .dout  (inh_d)
    );

    always_comb begin
        state_d = state_q;
        ts_inc  = 1'b0;
        inf_inc = 1'b0;
        init_p  = 1'b0;
        run_p   = 1'b0;
        rest_p  = 1'b0;
        stdp_p  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_init)      state_d = ST_INIT;
                else if (i_lern) state_d = ST_LERN;
                else if (i_infr) state_d = ST_INFR;
            end
            ST_INIT: begin
                init_p = entry_q;
                if (syn_rdy) state_d = ST_DONE;
            end
            ST_LERN, ST_LRST: begin
                run_p  = entry_q && (state_q == ST_LERN);
                rest_p = entry_q && (state_q == ST_LRST);
                ts_inc = entry_q;
                if (inh_rdy) state_d = ST_STDP;
            end
            ST_STDP: begin
                stdp_p = entry_q;
                if (stdp_rdy) begin
                    if (time_step_q < LERN_TS)       state_d = ST_LERN;
                    else if (time_step_q == TOTAL_TS) state_d = ST_DONE;
                    else                              state_d = ST_LRST;
                end
            end
            ST_INFR: begin
                run_p   = entry_q | inh_d;
                inf_inc = inh_d;
                if (inf_step_q >= LERN_TS) state_d = ST_IRST;
            end
            ST_IRST: begin
                rest_p  = inh_d;
                inf_inc = inh_d;
                if (inf_step_q == TOTAL_TS) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        // Abort wins over every transition and silences the cycle's pulses.
        if (i_abort && state_q != ST_IDLE && state_q != ST_DONE) begin
            state_d = ST_DONE;
            ts_inc  = 1'b0;
            inf_inc = 1'b0;
            init_p  = 1'b0;
            run_p   = 1'b0;
            rest_p  = 1'b0;
            stdp_p  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            entry_q     <= 1'b0;
            infr_flow_q <= 1'b0;
            time_step_q <= '0;
            inf_step_q  <= '0;
        end else begin
            state_q <= state_d;
            entry_q <= (state_d != state_q);
            if (state_q == ST_IDLE) infr_flow_q <= (state_d == ST_INFR);
            // Counters read zero throughout DONE, so clear on the way in.
            if (state_d == ST_DONE || state_q == ST_DONE) begin
                time_step_q <= '0;
                inf_step_q  <= '0;
            end else begin
                if (ts_inc && time_step_q < TOTAL_TS) time_step_q <= time_step_q + 1'b1;
                if (inf_inc && inf_step_q < TOTAL_TS) inf_step_q  <= inf_step_q + 1'b1;
            end
        end
    end

    assign ch.o_init     = init_p;
    assign ch.o_run      = run_p;
    assign ch.o_rest_run = rest_p;
    assign ch.o_stdp_run = stdp_p;

    assign o_cnt_clr   = (state_q == ST_IDLE);
    assign o_busy      = (state_q != ST_IDLE);
    assign o_done      = (state_q == ST_DONE);
    assign o_s_lern    = (state_q == ST_LERN);
    assign o_s_stdp    = (state_q == ST_STDP);
    assign o_s_infr    = (state_q == ST_INFR) || (state_q == ST_IRST);
    assign o_sub       = &time_step_q[SUB_LOG2-1:0];
    assign o_time_step = infr_flow_q ? inf_step_q : time_step_q;
endmodule
